mem_wb_stage: RTL and testbench

MEM/WB pipeline register and writeback driver for the 5-stage CPU. Sits directly downstream of the memory-access stage: captures its control, destination and ALU result at the stage boundary, takes the synchronous data-memory read data on the following cycle, and drives the register-file write port. A two-state hold machine preserves load data across stalls, so every retiring instruction writes exactly once.

---
 rtl/mem_wb_stage.sv | 115 +++++++++++
 tb/tb_mem_wb_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline register and register-file writeback driver.
//   Captures the MEM-stage control, destination and ALU result at the stage
//   boundary. Load data arrives from the synchronous data memory one cycle
//   later. A two-state hold machine (LIVE/HELD) keeps the load data seen in
//   the first stalled cycle, so a stalled load writes that value, and only
//   once, when the stall releases.
//
//   Optional feature macro: MEM_WB_RETIRE_CNT_EN adds the retire_count port
//   and a 32-bit retired-instruction counter.
//
// Ports
//   clk, rst            clock (rising edge) / async active-low reset
//   stall, flush        hold the WB register / replace it with a bubble
//   RegWrite_in, MemToReg_in, ret_in, DestReg_in, ALU_result_in
//                       instruction fields from MEM
//   MemRead_data        data-memory read data (valid the cycle after MEM)
//   reg_we, reg_waddr, reg_wdata   register-file write port
//   ret_commit          one-cycle pulse when a return retires
//   wb_busy             WB register holds a valid instruction
//   retire_count        retired-instruction count (macro builds only)
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        ret_in,
  input  logic [4:0]  DestReg_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] MemRead_data,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        ret_commit,
  output logic        wb_busy
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_count
`endif
);

  localparam logic [0:0] LIVE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        ret;
    logic [4:0]  dest;
    logic [31:0] alu;
  } wb_t;

  wb_t         wb_q;
  logic [0:0]  state_q;
  logic [31:0] hold_data;
  logic [31:0] ld_data;

  // WB register: flush beats stall, stall holds, otherwise accept MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q <= '0;
    end else if (!stall) begin
      wb_q.valid    <= 1'b1;
      wb_q.regwrite <= RegWrite_in;
      wb_q.memtoreg <= MemToReg_in;
      wb_q.ret      <= ret_in;
      wb_q.dest     <= DestReg_in;
      wb_q.alu      <= ALU_result_in;
    end
  end

  // The memory only presents load data for one cycle; when a load stalls in
  // WB, grab it on the first stalled edge and serve it until release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LIVE;
      hold_data <= '0;
    end else if (state_q == LIVE) begin
      if (stall && wb_q.valid && wb_q.memtoreg && !flush) begin
        state_q   <= HELD;
        hold_data <= MemRead_data;
      end
    end else begin
      if (!stall || flush) state_q <= LIVE;
    end
  end

  assign ld_data    = (state_q == HELD) ? hold_data : MemRead_data;
  assign reg_wdata  = wb_q.memtoreg ? ld_data : wb_q.alu;
  assign reg_waddr  = wb_q.dest;
  assign reg_we     = wb_q.valid & wb_q.regwrite & ~stall & (wb_q.dest != 5'd0);
  assign ret_commit = wb_q.valid & wb_q.ret & ~stall;
  assign wb_busy    = wb_q.valid;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_q;

  // Counts every retiring instruction, writing or not; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_q <= '0;
    end else if (wb_q.valid && !stall && !flush) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//   Self-checking bench for mem_wb_stage: directed scenarios with literal
//   expectations, then randomized traffic compared every cycle against a
//   behavioural model of the instruction sitting in writeback.
`timescale 1ns/1ps
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        RegWrite_in;
  logic        MemToReg_in;
  logic        ret_in;
  logic [4:0]  DestReg_in;
  logic [31:0] ALU_result_in;
  logic [31:0] MemRead_data;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        ret_commit;
  logic        wb_busy;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  int tests = 0;
  int fails = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in), .ret_in(ret_in),
    .DestReg_in(DestReg_in), .ALU_result_in(ALU_result_in),
    .MemRead_data(MemRead_data),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .ret_commit(ret_commit), .wb_busy(wb_busy)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The instruction occupying writeback, plus the load value it saw in its
  // first stalled cycle (if it has stalled as a load).
  typedef struct packed {
    bit        valid;
    bit        rw;
    bit        mtr;
    bit        ret;
    bit [4:0]  dest;
    bit [31:0] alu;
  } inst_t;

  inst_t     m_inst;
  bit        m_has_saved;
  bit [31:0] m_saved;
  bit [31:0] m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_inst      = '0;
      m_has_saved = 1'b0;
      m_saved     = '0;
      m_cnt       = '0;
    end else begin
      if (m_inst.valid && !stall && !flush) m_cnt = m_cnt + 1;
      if (flush) begin
        m_inst      = '0;
        m_has_saved = 1'b0;
      end else if (stall) begin
        if (m_inst.valid && m_inst.mtr && !m_has_saved) begin
          m_has_saved = 1'b1;
          m_saved     = MemRead_data;
        end
      end else begin
        m_inst      = '{1'b1, RegWrite_in, MemToReg_in, ret_in, DestReg_in, ALU_result_in};
        m_has_saved = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit        e_we, e_rc;
    bit [31:0] e_wd;
    bit        bad;
    e_we = m_inst.valid && m_inst.rw && !stall && (m_inst.dest != 5'd0);
    e_rc = m_inst.valid && m_inst.ret && !stall;
    e_wd = m_inst.mtr ? (m_has_saved ? m_saved : MemRead_data) : m_inst.alu;
    bad  = (reg_we !== e_we) || (ret_commit !== e_rc) || (wb_busy !== m_inst.valid) ||
           (reg_waddr !== m_inst.dest) || (reg_wdata !== e_wd);
`ifdef MEM_WB_RETIRE_CNT_EN
    bad = bad || (retire_count !== m_cnt);
`endif
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL model t=%0t got we=%0b wa=%0d wd=%h rc=%0b busy=%0b required we=%0b wa=%0d wd=%h rc=%0b busy=%0b",
               $time, reg_we, reg_waddr, reg_wdata, ret_commit, wb_busy,
               e_we, m_inst.dest, e_wd, e_rc, m_inst.valid);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_we"},   {31'd0, reg_we},     32'd0);
    chk({name, "_wa"},   {27'd0, reg_waddr},  32'd0);
    chk({name, "_wd"},   reg_wdata,           32'd0);
    chk({name, "_rc"},   {31'd0, ret_commit}, 32'd0);
    chk({name, "_busy"}, {31'd0, wb_busy},    32'd0);
`ifdef MEM_WB_RETIRE_CNT_EN
    chk({name, "_cnt"},  retire_count,        32'd0);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit rw, input bit mtr, input bit rt,
                        input bit [4:0] d, input bit [31:0] a);
    RegWrite_in   = rw;
    MemToReg_in   = mtr;
    ret_in        = rt;
    DestReg_in    = d;
    ALU_result_in = a;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; MemRead_data = '0;
    set_in(0, 0, 0, 5'd0, 32'd0);
    #2;
    chk_zero("reset");
    cyc();
    rst = 1'b1;

    // ALU op to r5: written in the following cycle.
    set_in(1, 0, 0, 5'd5, 32'h1234);
    cyc();
    set_in(0, 0, 0, 5'd0, 32'd0);
    #3;
    chk("alu_we", {31'd0, reg_we}, 32'd1);
    chk("alu_wa", {27'd0, reg_waddr}, 32'd5);
    chk("alu_wd", reg_wdata, 32'h1234);
    cyc();

    // Load to r7 stalled 3 cycles; first stalled-cycle data must win.
    set_in(1, 1, 0, 5'd7, 32'h99);
    cyc();
    set_in(0, 0, 0, 5'd0, 32'd0);
    stall = 1'b1; MemRead_data = 32'hAAAA5555;
    #3 chk("ld_stall1_we", {31'd0, reg_we}, 32'd0);
    cyc();
    MemRead_data = 32'hDEADBEEF;
    #3 chk("ld_stall2_we", {31'd0, reg_we}, 32'd0);
    cyc();
    #3 chk("ld_stall3_we", {31'd0, reg_we}, 32'd0);
    cyc();
    stall = 1'b0;
    #3;
    chk("ld_rel_we", {31'd0, reg_we}, 32'd1);
    chk("ld_rel_wa", {27'd0, reg_waddr}, 32'd7);
    chk("ld_rel_wd", reg_wdata, 32'hAAAA5555);
    cyc();
    #3 chk("ld_after_we", {31'd0, reg_we}, 32'd0);
    cyc();

    // Write to r0 is suppressed but the instruction still occupies WB.
    set_in(1, 0, 0, 5'd0, 32'hCAFE);
    cyc();
    set_in(0, 0, 0, 5'd0, 32'd0);
    #3;
    chk("r0_we", {31'd0, reg_we}, 32'd0);
    chk("r0_busy", {31'd0, wb_busy}, 32'd1);
    cyc();

    // Return with a 2-cycle stall: exactly one pulse on release.
    set_in(0, 0, 1, 5'd0, 32'd0);
    cyc();
    set_in(0, 0, 0, 5'd0, 32'd0);
    stall = 1'b1;
    #3 chk("ret_stall1", {31'd0, ret_commit}, 32'd0);
    cyc();
    #3 chk("ret_stall2", {31'd0, ret_commit}, 32'd0);
    cyc();
    stall = 1'b0;
    #3 chk("ret_rel", {31'd0, ret_commit}, 32'd1);
    cyc();
    #3 chk("ret_after", {31'd0, ret_commit}, 32'd0);
    cyc();

    // Flush + stall while a load is HELD: discarded, machine back to LIVE.
    set_in(1, 1, 1, 5'd9, 32'h55);
    cyc();
    set_in(0, 0, 0, 5'd0, 32'd0);
    stall = 1'b1; MemRead_data = 32'h11111111;
    cyc();
    flush = 1'b1;
    #3;
    chk("fl_we", {31'd0, reg_we}, 32'd0);
    chk("fl_rc", {31'd0, ret_commit}, 32'd0);
    cyc();
    flush = 1'b0; stall = 1'b0;
    set_in(1, 1, 0, 5'd10, 32'h77);
    #3;
    chk("fl_busy", {31'd0, wb_busy}, 32'd0);
    chk("fl_we2", {31'd0, reg_we}, 32'd0);
    cyc();
    set_in(0, 0, 0, 5'd0, 32'd0);
    stall = 1'b1; MemRead_data = 32'h22222222;
    cyc();
    stall = 1'b0; MemRead_data = 32'h33333333;
    #3;
    chk("fl_next_we", {31'd0, reg_we}, 32'd1);
    chk("fl_next_wa", {27'd0, reg_waddr}, 32'd10);
    chk("fl_next_wd", reg_wdata, 32'h22222222);
    cyc();

`ifdef MEM_WB_RETIRE_CNT_EN
    // Counter wrap: preset near the top, retire three instructions.
    force dut.retire_q = 32'hFFFFFFFE;
    m_cnt = 32'hFFFFFFFE;
    #1;
    release dut.retire_q;
    cyc(); cyc(); cyc();
    #2 chk("cnt_wrap", retire_count, 32'h00000001);
    cyc();
`endif

    // Randomized traffic, with one reset dropped in mid-stream.
    for (int i = 0; i < 1500; i++) begin
      stall         = ($urandom_range(0, 99) < 30);
      flush         = ($urandom_range(0, 99) < 8);
      RegWrite_in   = $urandom_range(0, 1);
      MemToReg_in   = $urandom_range(0, 1);
      ret_in        = ($urandom_range(0, 99) < 15);
      DestReg_in    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ALU_result_in = $urandom;
      MemRead_data  = $urandom;
      if (i == 700) begin
        #2 rst = 1'b0;
        #1 chk_zero("mid_reset");
        cyc();
        rst = 1'b1;
      end else begin
        cyc();
      end
    end

    stall = 1'b0; flush = 1'b0;
    set_in(0, 0, 0, 5'd0, 32'd0);
    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
